icache_direct: RTL
==================

Name: icache_direct

Overview:
Direct-mapped, read-only instruction cache that serves the pipelined datapath's fetch requests (imemREN/imemaddr -> ihit/imemload). It refills misses from the memory controller over a simple word-request/wait handshake (iREN/iaddr -> iwait/iload). The cache holds one-word blocks and keeps hit and miss counters for performance checks.

Parameters:
INDEX_W, 4, index bits; number of sets = 2**INDEX_W (16).
TAG_W, 26, tag bits; must equal 32 - INDEX_W - 2.

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
imemREN  in  1  datapath fetch request
imemaddr  in  32  datapath fetch byte address
ihit  out  1  fetch data valid this cycle
imemload  out  32  fetched instruction word
iREN  out  1  refill read request to memory controller
iaddr  out  32  refill word address
iwait  in  1  memory busy; data not ready while high
iload  in  32  refill data, valid when iREN && !iwait
hit_count  out  16  saturating count of hit cycles
miss_count  out  16  saturating count of misses

Behaviour:
- Reset: nRST is asynchronous, active-low; clock CLK.
- On reset:
  - all valid bits are cleared and the state is IDLE.
  - ihit=0, imemload=0, iREN=0, iaddr=0.
  - hit_count=0, miss_count=0.
- Address split:
  - [1:0] ignored (byte offset).
  - index = [INDEX_W+1:2].
  - tag = [31:INDEX_W+2].
- Storage per set: valid (1), tag (TAG_W), data (32). Only valid bits need reset; tag and data are don't-care until valid.
- Lookup is combinational: hit = imemREN && valid[index] && tag[index]==addr tag.
- State IDLE:
  - ihit = hit; imemload = data[index] when hit, else 0; iREN=0.
  - If imemREN && !hit: latch the word-aligned miss address ({imemaddr[31:2],2'b00}) into a miss register, increment miss_count, and go to FETCH next cycle.
  - If imemREN=0: stay in IDLE, no counter activity.
- State FETCH:
  - iREN=1, iaddr = miss register, ihit=0, imemload=0.
  - When iwait=0: write iload, the latched tag and valid=1 into the latched index; return to IDLE next cycle.
  - While iwait=1: hold all outputs.
- Miss timing: the request cycle, then at least one FETCH cycle, then the re-lookup in IDLE hits. Minimum miss-to-ihit latency is 2 cycles (iwait=0 on the first FETCH cycle). No critical-word bypass: data is returned only via the hit path.
- Changes to imemaddr or imemREN during FETCH are ignored. The fill always completes for the latched address. After the return to IDLE the current imemaddr is looked up, so a fill may be useless to the new address (acceptable).
- Conflict: a fill overwrites the set unconditionally; there is no dirty state (read-only).
- Counters:
  - hit_count increments every cycle ihit=1.
  - miss_count increments once per IDLE->FETCH transition.
  - Both saturate at 16'hFFFF and never wrap.
- Reset asserted mid-FETCH: iREN drops immediately (asynchronously), the refill is abandoned and all sets are invalidated; any memory response after that is ignored.
- iaddr holds its last value in IDLE (0 after reset); it is only meaningful when iREN=1.
- The block sits between the datapath and the memory arbiter. It assumes the arbiter holds iload stable for the cycle iwait=0.

Test Plan:
- Reset, then imemREN=1, imemaddr=0x00000000, iwait high 2 cycles, iload=0x20010005 -> ihit=0 for 4 cycles (miss cycle plus 3 FETCH), iREN=1/iaddr=0 during FETCH. Next cycle ihit=1, imemload=0x20010005, miss_count=1, hit_count=1.
- After the fill, request 0x00000000 three consecutive cycles -> ihit=1 every cycle, iREN=0, hit_count +3, miss_count unchanged.
- Fill 0x00000000, then request 0x00000040 (same index 0, different tag), iload=0xDEADBEEF -> miss, iaddr=0x40. Then 0x40 hits with 0xDEADBEEF, and a later 0x00000000 misses again; miss_count=3.
- Miss on 0x00000004, then change imemaddr to 0x00000008 during FETCH -> iaddr stays 0x4 and set 1 is filled. Back in IDLE, 0x8 misses and iaddr=0x8.
- Pull nRST low on the second FETCH cycle -> iREN=0 immediately and counters read 0. After release, the previously filled address misses.
- Force hit_count to 0xFFFE via repeated hits, then hit 3 more cycles -> hit_count holds 0xFFFF.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with one-word blocks.
// Misses are refilled over a word request/wait handshake; hit and miss cycles are counted.
module icache_direct #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 26
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int SETS = 1 << INDEX_W;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t             state_r;
  logic [SETS-1:0]    valid_r;
  logic [TAG_W-1:0]   tag_r  [SETS];
  logic [31:0]        data_r [SETS];
  logic [31:0]        miss_addr_r;
  logic [15:0]        hit_count_r;
  logic [15:0]        miss_count_r;

  logic [INDEX_W-1:0] index_s;
  logic [TAG_W-1:0]   tag_s;
  logic [INDEX_W-1:0] fill_index_s;
  logic [TAG_W-1:0]   fill_tag_s;
  logic               hit_s;
  logic               lookup_hit_s;
  logic               miss_s;
  logic               fill_s;
  logic               unused_offset_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      sat_inc = value;
    end else begin
      sat_inc = value + 16'd1;
    end
  endfunction

  assign index_s         = imemaddr[INDEX_W+1:2];
  assign tag_s           = imemaddr[31:INDEX_W+2];
  assign fill_index_s    = miss_addr_r[INDEX_W+1:2];
  assign fill_tag_s      = miss_addr_r[31:INDEX_W+2];
  assign unused_offset_s = ^imemaddr[1:0];

  // Combinational lookup and the IDLE/FETCH qualified hit, miss and fill strobes.
  always_comb begin
    lookup_hit_s = 1'b0;
    if (imemREN && valid_r[index_s] && (tag_r[index_s] == tag_s)) begin
      lookup_hit_s = 1'b1;
    end else begin
      lookup_hit_s = 1'b0;
    end
    hit_s  = (state_r == IDLE) && lookup_hit_s;
    miss_s = (state_r == IDLE) && imemREN && !lookup_hit_s;
    fill_s = (state_r == FETCH) && !iwait;
  end

  // Datapath and memory-side outputs; data is only ever returned through the hit path.
  always_comb begin
    ihit     = hit_s;
    iREN     = (state_r == FETCH);
    iaddr    = miss_addr_r;
    if (hit_s) begin
      imemload = data_r[index_s];
    end else begin
      imemload = 32'h0000_0000;
    end
  end

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;

  // Control state, valid bits, latched miss address and performance counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r      <= IDLE;
      valid_r      <= '0;
      miss_addr_r  <= 32'h0000_0000;
      hit_count_r  <= 16'h0000;
      miss_count_r <= 16'h0000;
    end else begin
      if (hit_s) begin
        hit_count_r <= sat_inc(hit_count_r);
      end else begin
        hit_count_r <= hit_count_r;
      end
      case (state_r)
        IDLE: begin
          if (miss_s) begin
            miss_addr_r  <= {imemaddr[31:2], 2'b00};
            miss_count_r <= sat_inc(miss_count_r);
            state_r      <= FETCH;
          end else begin
            state_r <= IDLE;
          end
        end
        FETCH: begin
          // The fill completes for the latched address regardless of imemaddr now.
          if (fill_s) begin
            valid_r[fill_index_s] <= 1'b1;
            state_r               <= IDLE;
          end else begin
            state_r <= FETCH;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; they are meaningless until the set is valid.
  always_ff @(posedge CLK) begin
    if (fill_s) begin
      tag_r[fill_index_s]  <= fill_tag_s;
      data_r[fill_index_s] <= iload;
    end else begin
      tag_r[fill_index_s]  <= tag_r[fill_index_s];
      data_r[fill_index_s] <= data_r[fill_index_s];
    end
  end

endmodule
